// File: rtl/cordic_pkg.sv
// ----------------------------------------------------------------------------
// cordic_pkg
// Shared types and defaults for the CORDIC flow-control wrapper.
//   mode_e       : request mode (arctan or sin/cos)
//   cordic_res_t : one pipeline result {cos, sin, atan} at the default width
// ----------------------------------------------------------------------------
package cordic_pkg;

    localparam int DEF_WIDTH   = 32;
    localparam int DEF_LATENCY = 13;

    typedef enum logic {
        MODE_ATAN   = 1'b0,
        MODE_SINCOS = 1'b1
    } mode_e;

    typedef struct packed {
        logic [DEF_WIDTH-1:0] cos;
        logic [DEF_WIDTH-1:0] sin;
        logic [DEF_WIDTH-1:0] atan;
    } cordic_res_t;

endpackage

// File: rtl/sync_fifo.sv
// ----------------------------------------------------------------------------
// sync_fifo
// Single-clock show-ahead FIFO. The head entry is visible on rdata whenever
// empty=0. A push and a pop in the same cycle are both performed, including
// when the FIFO is full (the pop frees the slot the push uses).
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   push, wdata     write request and data (ignored when full without pop)
//   pop             remove head entry (ignored when empty)
//   rdata           head entry
//   full, empty     occupancy flags
//   count           number of stored entries, 0..DEPTH
// ----------------------------------------------------------------------------
module sync_fifo
    import cordic_pkg::*;
#(
    parameter int DW    = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [DW-1:0]            wdata,
    input  logic                     pop,
    output logic [DW-1:0]            rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;

    logic w_pop;
    logic w_push;

    assign w_pop  = pop && (r_count != '0);
    // Pop frees a slot in the same cycle, so a push at full is still legal.
    assign w_push = push && ((r_count != FULL_CNT) || w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign rdata = r_mem[r_rptr];
    assign full  = (r_count == FULL_CNT);
    assign empty = (r_count == '0);
    assign count = r_count;

endmodule

// File: rtl/cordic_flow_ctrl.sv
// ----------------------------------------------------------------------------
// cordic_flow_ctrl
// Flow-control wrapper around a fixed-latency CORDIC pipeline with no
// backpressure. Requests are accepted only while a result-FIFO slot can be
// reserved (credit = outstanding < FIFO_DEPTH), so every result the pipeline
// produces is guaranteed a place in the result FIFO.
// Ports:
//   clk, rst_n                         clock, synchronous active-low reset
//   req_valid/req_ready                request handshake
//   req_mode, req_x/y/z                request mode and operands
//   cdc_valid_in, cdc_mode, cdc_x/y/z  registered issue into the pipeline
//   cdc_valid_out, cdc_cos/sin/tan_in  pipeline results
//   res_valid/res_ready                result handshake
//   res_mode, res_cos/sin/atan         head result (zero when res_valid=0)
//   outstanding                        credits in use (accepted, not popped)
//   orphan_err                         sticky: result with nothing in flight
// ----------------------------------------------------------------------------
module cordic_flow_ctrl
    import cordic_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int LATENCY    = DEF_LATENCY,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_mode,
    input  logic [WIDTH-1:0]              req_x,
    input  logic [WIDTH-1:0]              req_y,
    input  logic [WIDTH-1:0]              req_z,
    output logic                          cdc_valid_in,
    output logic                          cdc_mode,
    output logic [WIDTH-1:0]              cdc_x,
    output logic [WIDTH-1:0]              cdc_y,
    output logic [WIDTH-1:0]              cdc_z,
    input  logic                          cdc_valid_out,
    input  logic [WIDTH-1:0]              cdc_cos,
    input  logic [WIDTH-1:0]              cdc_sin,
    input  logic [WIDTH-1:0]              cdc_tan_in,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic                          res_mode,
    output logic [WIDTH-1:0]              res_cos,
    output logic [WIDTH-1:0]              res_sin,
    output logic [WIDTH-1:0]              res_atan,
    output logic [$clog2(FIFO_DEPTH):0]   outstanding,
    output logic                          orphan_err
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int RW = 3 * WIDTH;
    localparam logic [CW-1:0] DEPTH_CNT = CW'(FIFO_DEPTH);

    generate
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("cordic_flow_ctrl: FIFO_DEPTH must be a power of two >= 2");
        end
        if (LATENCY < 1) begin : g_bad_latency
            $error("cordic_flow_ctrl: LATENCY must be >= 1");
        end
    endgenerate

    // Issue registers
    logic              r_cdc_valid;
    mode_e             r_mode;
    logic [WIDTH-1:0]  r_x;
    logic [WIDTH-1:0]  r_y;
    logic [WIDTH-1:0]  r_z;

    logic [CW-1:0]     r_outstanding;
    logic              r_orphan;

    logic              w_accept;
    logic              w_pop;
    logic              w_capture;
    logic [CW-1:0]     w_inflight;

    logic [RW-1:0]     w_res_wdata;
    logic [RW-1:0]     w_res_rdata;
    logic              w_res_full;
    logic              w_res_empty;
    logic [CW-1:0]     w_res_count;

    logic              w_tag_rdata;
    logic              w_tag_full;
    logic              w_tag_empty;
    logic [CW-1:0]     w_tag_count;

    // Tag FIFO occupancy always tracks outstanding; its flags are redundant.
    logic              w_unused;
    assign w_unused = ^{w_res_full, w_tag_full, w_tag_empty, w_tag_count};

    // Handshakes: both sides are forced idle while reset is asserted.
    assign req_ready = rst_n && (r_outstanding < DEPTH_CNT);
    assign res_valid = rst_n && !w_res_empty;
    assign w_accept  = req_valid && req_ready;
    assign w_pop     = res_valid && res_ready;

    // Results already captured hold credits too; the remainder are still
    // travelling through the pipeline.
    assign w_inflight = r_outstanding - w_res_count;
    assign w_capture  = cdc_valid_out && (w_inflight != '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cdc_valid   <= 1'b0;
            r_mode        <= MODE_ATAN;
            r_x           <= '0;
            r_y           <= '0;
            r_z           <= '0;
            r_outstanding <= '0;
            r_orphan      <= 1'b0;
        end else begin
            r_cdc_valid <= w_accept;
            if (w_accept) begin
                r_mode <= mode_e'(req_mode);
                r_x    <= req_x;
                r_y    <= req_y;
                r_z    <= req_z;
            end
            case ({w_accept, w_pop})
                2'b10:   r_outstanding <= r_outstanding + 1'b1;
                2'b01:   r_outstanding <= r_outstanding - 1'b1;
                default: r_outstanding <= r_outstanding;
            endcase
            if (cdc_valid_out && (w_inflight == '0)) begin
                r_orphan <= 1'b1;
            end
        end
    end

    assign w_res_wdata = {cdc_cos, cdc_sin, cdc_tan_in};

    sync_fifo #(
        .DW    (RW),
        .DEPTH (FIFO_DEPTH)
    ) u_res_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_capture),
        .wdata (w_res_wdata),
        .pop   (w_pop),
        .rdata (w_res_rdata),
        .full  (w_res_full),
        .empty (w_res_empty),
        .count (w_res_count)
    );

    sync_fifo #(
        .DW    (1),
        .DEPTH (FIFO_DEPTH)
    ) u_tag_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_accept),
        .wdata (req_mode),
        .pop   (w_pop),
        .rdata (w_tag_rdata),
        .full  (w_tag_full),
        .empty (w_tag_empty),
        .count (w_tag_count)
    );

    assign cdc_valid_in = r_cdc_valid;
    assign cdc_mode     = r_mode;
    assign cdc_x        = r_x;
    assign cdc_y        = r_y;
    assign cdc_z        = r_z;

    assign res_mode = res_valid ? w_tag_rdata : 1'b0;
    assign res_cos  = res_valid ? w_res_rdata[RW-1:2*WIDTH]      : '0;
    assign res_sin  = res_valid ? w_res_rdata[2*WIDTH-1:WIDTH]   : '0;
    assign res_atan = res_valid ? w_res_rdata[WIDTH-1:0]         : '0;

    assign outstanding = r_outstanding;
    assign orphan_err  = r_orphan;

endmodule

// File: tb/tb_cordic_flow_ctrl.sv
// ----------------------------------------------------------------------------
// tb_cordic_flow_ctrl
// Directed bench for cordic_flow_ctrl. The pipeline model is a 13-stage delay
// line that returns cos=x, sin=y, tan_in=z of the issued request, so every
// popped result can be compared against the request that produced it.
// ----------------------------------------------------------------------------
module tb_cordic_flow_ctrl;
    import cordic_pkg::*;

    localparam int W   = 32;
    localparam int LAT = 13;
    localparam int D   = 16;

    typedef struct packed {
        logic         mode;
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] z;
    } req_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid, req_ready, req_mode;
    logic [W-1:0]  req_x, req_y, req_z;
    logic          cdc_valid_in, cdc_mode;
    logic [W-1:0]  cdc_x, cdc_y, cdc_z;
    logic          cdc_valid_out;
    logic [W-1:0]  cdc_cos, cdc_sin, cdc_tan_in;
    logic          res_valid, res_ready, res_mode;
    logic [W-1:0]  res_cos, res_sin, res_atan;
    logic [4:0]    outstanding;
    logic          orphan_err;
    logic          force_orph;

    int n_chk  = 0;
    int n_fail = 0;
    int seq    = 0;
    req_t sb[$];

    always #5 clk = ~clk;

    cordic_flow_ctrl #(.WIDTH(W), .LATENCY(LAT), .FIFO_DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
        .req_x(req_x), .req_y(req_y), .req_z(req_z),
        .cdc_valid_in(cdc_valid_in), .cdc_mode(cdc_mode),
        .cdc_x(cdc_x), .cdc_y(cdc_y), .cdc_z(cdc_z),
        .cdc_valid_out(cdc_valid_out),
        .cdc_cos(cdc_cos), .cdc_sin(cdc_sin), .cdc_tan_in(cdc_tan_in),
        .res_valid(res_valid), .res_ready(res_ready), .res_mode(res_mode),
        .res_cos(res_cos), .res_sin(res_sin), .res_atan(res_atan),
        .outstanding(outstanding), .orphan_err(orphan_err)
    );

    // Pipeline model: fixed delay, shares reset with the DUT.
    logic pv [LAT];
    req_t pd [LAT];
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < LAT; k++) pv[k] <= 1'b0;
        end else begin
            pv[0] <= cdc_valid_in;
            pd[0] <= {cdc_mode, cdc_x, cdc_y, cdc_z};
            for (int k = 1; k < LAT; k++) begin
                pv[k] <= pv[k-1];
                pd[k] <= pd[k-1];
            end
        end
    end
    assign cdc_valid_out = pv[LAT-1] | force_orph;
    assign cdc_cos       = pd[LAT-1].x;
    assign cdc_sin       = pd[LAT-1].y;
    assign cdc_tan_in    = pd[LAT-1].z;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Records accepts, checks pops against the scoreboard, then advances one
    // cycle and settles 1 time unit past the edge.
    task automatic tick();
        req_t e;
        if (req_valid && req_ready) begin
            sb.push_back({req_mode, req_x, req_y, req_z});
            seq++;
        end
        if (res_valid && res_ready) begin
            if (sb.size() == 0) begin
                chk("pop_unexpected", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("pop_mode", 64'(res_mode), 64'(e.mode));
                chk("pop_cos",  64'(res_cos),  64'(e.x));
                chk("pop_sin",  64'(res_sin),  64'(e.y));
                chk("pop_atan", 64'(res_atan), 64'(e.z));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive_seq();
        req_mode = seq[0];
        req_x    = 32'h1000_0000 + seq;
        req_y    = 32'h2000_0000 + seq;
        req_z    = 32'h3000_0000 + seq;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #0;
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_res_valid", 64'(res_valid), 64'd0);
        tick();
        sb.delete();
        rst_n = 1'b1;
        #0;
    endtask

    // 20 cycles of requests with res_ready=0: credit must stop at 16.
    task automatic fill20();
        int nacc;
        nacc = 0;
        res_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            req_valid = 1'b1;
            drive_seq();
            if (i == 16) chk("fill_rdy_low", 64'(req_ready), 64'd0);
            if (req_ready) nacc++;
            tick();
        end
        req_valid = 1'b0;
        chk("fill_accepts", 64'(nacc), 64'd16);
        chk("fill_outstanding", 64'(outstanding), 64'd16);
        chk("fill_req_ready", 64'(req_ready), 64'd0);
        // Last accept at cycle 15 lands at cycle 30; we are at cycle 20.
        for (int i = 0; i < 12; i++) tick();
        chk("fill_res_valid", 64'(res_valid), 64'd1);
        chk("fill_orphan", 64'(orphan_err), 64'd0);
    endtask

    initial begin
        int lat;
        rst_n = 1'b0; req_valid = 1'b0; req_mode = 1'b0;
        req_x = '0; req_y = '0; req_z = '0;
        res_ready = 1'b0; force_orph = 1'b0;
        #1;
        tick();
        do_reset();
        tick();

        // Reset state
        chk("rst_cdc_valid", 64'(cdc_valid_in), 64'd0);
        chk("rst_cdc_z", 64'(cdc_z), 64'd0);
        chk("rst_outstanding", 64'(outstanding), 64'd0);
        chk("rst_orphan", 64'(orphan_err), 64'd0);
        chk("rst_res_cos", 64'(res_cos), 64'd0);
        chk("idle_req_ready", 64'(req_ready), 64'd1);

        // Single sin/cos request
        req_valid = 1'b1; req_mode = 1'b1;
        req_x = 32'h0000_1111; req_y = 32'h0000_2222; req_z = 32'h0000_1000;
        tick();
        req_valid = 1'b0;
        chk("one_cdc_valid_c1", 64'(cdc_valid_in), 64'd1);
        chk("one_cdc_mode", 64'(cdc_mode), 64'd1);
        chk("one_cdc_z", 64'(cdc_z), 64'h1000);
        chk("one_outstanding", 64'(outstanding), 64'd1);
        for (int c = 1; c < 15; c++) begin
            if (c == 2) begin
                chk("one_cdc_valid_c2", 64'(cdc_valid_in), 64'd0);
                chk("one_cdc_z_hold", 64'(cdc_z), 64'h1000);
            end
            chk("one_res_early", 64'(res_valid), 64'd0);
            tick();
        end
        chk("one_res_valid_c15", 64'(res_valid), 64'd1);
        chk("one_res_mode", 64'(res_mode), 64'd1);
        chk("one_res_cos", 64'(res_cos), 64'h1111);
        chk("one_res_sin", 64'(res_sin), 64'h2222);
        chk("one_res_atan", 64'(res_atan), 64'h1000);
        chk("one_out_c15", 64'(outstanding), 64'd1);
        tick();
        chk("one_res_hold", 64'(res_cos), 64'h1111);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("one_res_gone", 64'(res_valid), 64'd0);
        chk("one_res_zero", 64'(res_cos), 64'd0);
        chk("one_out_zero", 64'(outstanding), 64'd0);

        // Backpressure fill, then drain in order
        fill20();
        res_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("drain_vld", 64'(res_valid), 64'd1);
            if (i == 0) chk("drain_rdy_c0", 64'(req_ready), 64'd0);
            if (i == 1) chk("drain_rdy_c1", 64'(req_ready), 64'd1);
            tick();
        end
        chk("drain_empty", 64'(res_valid), 64'd0);
        chk("drain_out", 64'(outstanding), 64'd0);

        // Refill, then stream with accept and pop coinciding every cycle.
        fill20();
        res_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            req_valid = 1'b1;
            drive_seq();
            chk("stream_vld", 64'(res_valid), 64'd1);
            if (i >= 1) chk("stream_out", 64'(outstanding), 64'd15);
            tick();
        end
        req_valid = 1'b0;
        lat = 0;
        while (outstanding != 0 && lat < 40) begin
            tick();
            lat++;
        end
        chk("stream_drained", 64'(outstanding), 64'd0);
        chk("stream_sb_empty", 64'(sb.size()), 64'd0);
        chk("stream_orphan", 64'(orphan_err), 64'd0);
        res_ready = 1'b0;

        // Orphan result
        do_reset();
        force_orph = 1'b1;
        tick();
        force_orph = 1'b0;
        chk("orph_set", 64'(orphan_err), 64'd1);
        chk("orph_no_push", 64'(res_valid), 64'd0);
        for (int i = 0; i < 3; i++) tick();
        chk("orph_sticky", 64'(orphan_err), 64'd1);
        chk("orph_res_valid", 64'(res_valid), 64'd0);

        // Reset mid-stream: 8 accepted, 3 landed, 5 in flight
        do_reset();
        chk("rst2_orphan", 64'(orphan_err), 64'd0);
        for (int i = 0; i < 8; i++) begin
            req_valid = 1'b1;
            drive_seq();
            tick();
        end
        req_valid = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        chk("mid_outstanding", 64'(outstanding), 64'd8);
        chk("mid_res_valid", 64'(res_valid), 64'd1);
        do_reset();
        chk("mid_rst_out", 64'(outstanding), 64'd0);
        chk("mid_rst_res", 64'(res_valid), 64'd0);
        chk("mid_rst_cdc", 64'(cdc_valid_in), 64'd0);
        chk("mid_rst_orphan", 64'(orphan_err), 64'd0);

        // Fresh request after reset completes with nominal latency.
        req_valid = 1'b1;
        drive_seq();
        tick();
        req_valid = 1'b0;
        lat = 1;
        while (!res_valid && lat < 40) begin
            tick();
            lat++;
        end
        chk("post_rst_latency", 64'(lat), 64'd15);
        for (int i = 0; i < 12; i++) tick();
        chk("post_rst_orphan", 64'(orphan_err), 64'd0);
        res_ready = 1'b1;
        tick();
        chk("post_rst_done", 64'(outstanding), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cordic_flow_ctrl.md
Name: cordic_flow_ctrl

Overview:
Flow-control wrapper that sits directly upstream and downstream of the 32-bit CORDIC pipeline.
- Accepts sin/cos and arctan requests over a valid/ready interface and issues them into the pipeline. The pipeline has no backpressure.
- Captures the pipeline results into a result FIFO and presents them to the consumer over valid/ready.
- Credit counting guarantees that every issued request has a FIFO slot reserved, so results are never lost.

Parameters:
- WIDTH, 32, datapath width of x/y/z/cos/sin/atan (signed fixed point, passed through unchanged).
- LATENCY, 13, cycles from cdc_valid_in to cdc_valid_out of the attached pipeline (equals its NUM_STAGES).
- FIFO_DEPTH, 16, result/tag FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when req_valid && req_ready
- req_mode  in  1  0 = arctan(y/x), 1 = sin/cos(z)
- req_x, req_y, req_z  in  WIDTH each  request operands
- cdc_valid_in  out  1  to pipeline valid_in
- cdc_mode  out  1  to pipeline mode
- cdc_x, cdc_y, cdc_z  out  WIDTH each  to pipeline operands
- cdc_valid_out  in  1  from pipeline valid_out
- cdc_cos, cdc_sin, cdc_tan_in  in  WIDTH each  from pipeline results
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts
- res_mode  out  1  mode of the head result
- res_cos, res_sin, res_atan  out  WIDTH each  head result
- outstanding  out  $clog2(FIFO_DEPTH)+1  credits in use
- orphan_err  out  1  sticky: result arrived with nothing in flight

Behaviour:
- Reset (rst_n low at posedge) sets cdc_valid_in=0, cdc_mode/x/y/z=0, both FIFOs empty, outstanding=0, orphan_err=0.
  - While in reset: req_ready=0 and res_valid=0.
  - Reset mid-operation discards all in-flight and queued results. The attached pipeline shares rst_n.
- req_ready = (outstanding < FIFO_DEPTH). It is a function of state only, never of req_valid.
- Issue (accept):
  - cdc_valid_in is registered; it equals 1 in the cycle after accept, otherwise 0.
  - cdc_mode/x/y/z load on accept and hold their value otherwise.
  - Back-to-back accepts issue one request per cycle.
- Tag FIFO: req_mode is pushed on accept and popped on result pop. It never overflows, because pushes are credit-gated.
- outstanding:
  - +1 on accept, -1 on result pop (res_valid && res_ready).
  - Accept and pop in the same cycle leave it unchanged.
  - Range 0..FIFO_DEPTH.
- In-flight count = outstanding - result FIFO occupancy.
- Capture, on cdc_valid_out=1:
  - If in-flight > 0: push {cos, sin, tan_in} into the result FIFO.
  - If in-flight == 0: drop the result and set orphan_err (sticky until reset).
- Result FIFO is show-ahead.
  - A push at cycle t is visible as res_valid=1 at t+1.
  - res_* hold stable while res_valid && !res_ready.
  - Push and pop in the same cycle, including when full or with one entry, are both performed.
- Latency from accept (cycle 0) to res_valid: cycle LATENCY+2 (15 at defaults), given an empty FIFO.
- Throughput: 1 result/cycle when res_ready is held at 1.
- When res_valid=1: res_mode = tag FIFO head, and res_atan = stored tan_in. No arithmetic is done on the data.
- When res_valid=0: res_* = 0.

Decomposition:
- Package cordic_pkg:
  - mode_e (MODE_ATAN=1'b0, MODE_SINCOS=1'b1).
  - cordic_res_t struct {cos, sin, atan} of WIDTH.
  - Localparams DEF_WIDTH=32, DEF_LATENCY=13.
- Sub-module sync_fifo #(DW, DEPTH):
  - Show-ahead, with push/pop/full/empty/count.
  - Instantiated twice: results (3*WIDTH) and tags (1 bit).
- The credit counter and issue register live in the top module.

Test Plan:
- Single request: the bench pipeline model delays cdc_* by 13 cycles. Accept mode=1, z=0x0000_1000 at cycle 0 -> cdc_valid_in=1 at cycle 1 only; result (cos=0x1111, sin=0x2222) gives res_valid=1 at cycle 15 with res_mode=1 and outstanding=1, then drops to 0 after pop.
- Backpressure fill: res_ready=0, req_valid=1 for 20 cycles -> exactly 16 accepts, req_ready=0 from cycle 16 onward, outstanding=16, and 16 results queued with no orphan_err.
- Drain and refill: from the full state, raise res_ready=1 -> one pop per cycle in issue order (tags alternate 0/1 as issued), and req_ready returns 1 the cycle after the first pop.
- Simultaneous push/pop at full and at one entry -> occupancy unchanged, data order preserved, outstanding unchanged when accept and pop coincide.
- Orphan: after reset, force cdc_valid_out=1 with no accepts -> no push, res_valid stays 0, orphan_err=1 and held.
- Reset mid-stream: 5 requests in flight and 3 queued, then assert rst_n=0 for one cycle -> outstanding=0, res_valid=0, cdc_valid_in=0, orphan_err=0, and a new request completes normally afterwards.
